// File: rtl/pic_pkg.sv
// Shared definitions for the priority interrupt controller core:
// acknowledge-sequence FSM states and the spurious channel id.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } pic_state_e;

  localparam int PIC_NUM_IRQ_DEFAULT = 8;

  // Id reported when an acknowledge arrives with nothing eligible:
  // always the highest channel number.
  function automatic int spurious_id(input int num_irq);
    return num_irq - 1;
  endfunction

endpackage

// File: rtl/pic_priority_core_if.sv
// CPU-side acknowledge / EOI bus of the interrupt controller.
// master = CPU (drives INTA and EOI strobes), slave = controller.
interface pic_priority_core_if #(
  parameter int NUM_IRQ = 8
);
  localparam int ID_W = $clog2(NUM_IRQ);

  logic            inta_n;
  logic            eoi_ns;
  logic            eoi_sp;
  logic [ID_W-1:0] eoi_id;
  logic            int_out;
  logic [7:0]      vector;
  logic            vector_valid;

  modport master (
    output inta_n, eoi_ns, eoi_sp, eoi_id,
    input  int_out, vector, vector_valid
  );

  modport slave (
    input  inta_n, eoi_ns, eoi_sp, eoi_id,
    output int_out, vector, vector_valid
  );

endinterface

// File: rtl/pic_prio_resolver.sv
// Combinational circular priority resolver. Walks channels from the
// highest rank (pri_low+1) down to the lowest (pri_low); the first
// in-service bit met blocks every request ranked below it.
module pic_prio_resolver #(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [ID_W-1:0]    pri_low,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  logic            blocked;
  logic [ID_W-1:0] ch;

  // Priority walk: stop at the first request, or at the first in-service bit
  always_comb begin
    valid   = 1'b0;
    id      = '0;
    blocked = 1'b0;
    ch      = '0;
    for (int k = 1; k <= NUM_IRQ; k++) begin
      ch = pri_low + ID_W'(k);
      if (!valid && !blocked) begin
        if (isr[ch]) begin
          blocked = 1'b1;
        end else if (req[ch]) begin
          valid = 1'b1;
          id    = ch;
        end
      end
    end
  end

endmodule

// File: rtl/pic_priority_core.sv
// Priority interrupt controller core: request capture (edge/level),
// fully nested circular priority, two-pulse INTA sequence, AEOI and
// specific / non-specific EOI.
// Optional feature macro: PIC_PRIORITY_ROTATE_EN enables priority
// rotation on EOI (rot_eoi, pri_low). Without it priority is fixed
// with channel 0 highest and rot_eoi is ignored.
module pic_priority_core
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = PIC_NUM_IRQ_DEFAULT,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IRQ-1:0]   irq_in,
  input  logic                 ltim,
  input  logic                 aeoi,
  input  logic [NUM_IRQ-1:0]   imr,
  input  logic [7:0]           vec_base,
  input  logic                 rot_eoi,
  pic_priority_core_if.slave   bus,
  output logic [NUM_IRQ-1:0]   irr_out,
  output logic [NUM_IRQ-1:0]   isr_out,
  output logic [ID_W-1:0]      pri_low
);

  localparam logic [ID_W-1:0] SPUR_ID = ID_W'(spurious_id(NUM_IRQ));

  pic_state_e         state, state_n;
  logic [NUM_IRQ-1:0] irr, isr, irq_q;
  logic [NUM_IRQ-1:0] irr_n, isr_n, isr_set, isr_clr, eoi_clr, irr_take;
  logic               inta_q, inta_fall, inta_rise;
  logic               int_out_r, int_out_n;
  logic [7:0]         vector_r;
  logic [ID_W-1:0]    frz_id;
  logic               frz_real;
  logic               take, ack_done, aeoi_clr;
  logic               elig_vld, isr_any, eoi_hit;
  logic [ID_W-1:0]    elig_id, isr_top, eoi_k;
  logic [ID_W-1:0]    pri_low_w;
  logic [ID_W-1:0]    take_id;
  logic               unused_vec_lo;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] i);
    logic [NUM_IRQ-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  assign inta_fall     = inta_q & ~bus.inta_n;
  assign inta_rise     = ~inta_q & bus.inta_n;
  assign unused_vec_lo = ^vec_base[ID_W-1:0];

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_elig (
    .req     (irr & ~imr),
    .isr     (isr),
    .pri_low (pri_low_w),
    .valid   (elig_vld),
    .id      (elig_id)
  );

  // Highest-ranked in-service bit, the target of a non-specific EOI
  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_top (
    .req     (isr),
    .isr     ({NUM_IRQ{1'b0}}),
    .pri_low (pri_low_w),
    .valid   (isr_any),
    .id      (isr_top)
  );

  // INTA sequence next state and int_out
  always_comb begin
    state_n   = state;
    int_out_n = int_out_r;
    take      = 1'b0;
    ack_done  = 1'b0;
    case (state)
      IDLE: begin
        if (inta_fall) begin
          take      = 1'b1;
          int_out_n = 1'b0;
          state_n   = ACK1;
        end else begin
          int_out_n = int_out_r | elig_vld;
        end
      end
      ACK1: begin
        int_out_n = 1'b0;
        if (inta_fall) state_n = ACK2;
      end
      ACK2: begin
        int_out_n = 1'b0;
        if (inta_rise) begin
          state_n  = IDLE;
          ack_done = 1'b1;
        end
      end
      default: begin
        int_out_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // ISR / IRR set and clear masks; a set beats a clear on the same bit
  always_comb begin
    take_id  = elig_vld ? elig_id : SPUR_ID;
    isr_set  = (take && elig_vld) ? onehot(elig_id) : '0;
    irr_take = isr_set;
    aeoi_clr = ack_done && aeoi && frz_real;
    eoi_hit  = 1'b0;
    eoi_k    = '0;
    if (bus.eoi_sp) begin
      eoi_k   = bus.eoi_id;
      eoi_hit = isr[bus.eoi_id];
    end else if (bus.eoi_ns) begin
      eoi_k   = isr_top;
      eoi_hit = isr_any;
    end
    eoi_clr = eoi_hit ? onehot(eoi_k) : '0;
    isr_clr = eoi_clr | (aeoi_clr ? onehot(frz_id) : '0);
    isr_n   = (isr & ~isr_clr) | isr_set;
    if (ltim) irr_n = irq_in;
    else      irr_n = (irr & ~irr_take) | (irq_in & ~irq_q);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irr       <= '0;
      isr       <= '0;
      irq_q     <= '0;
      inta_q    <= 1'b1;
      int_out_r <= 1'b0;
      vector_r  <= '0;
      frz_id    <= '0;
      frz_real  <= 1'b0;
    end else begin
      state     <= state_n;
      irr       <= irr_n;
      isr       <= isr_n;
      irq_q     <= irq_in;
      inta_q    <= bus.inta_n;
      int_out_r <= int_out_n;
      if (take) begin
        frz_id   <= take_id;
        frz_real <= elig_vld;
        vector_r <= {vec_base[7:ID_W], take_id};
      end
    end
  end

`ifdef PIC_PRIORITY_ROTATE_EN
  logic [ID_W-1:0] pri_low_r;

  // Rotation: the channel just serviced becomes the lowest priority
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_low_r <= ID_W'(NUM_IRQ - 1);
    end else if (rot_eoi) begin
      if (eoi_hit)       pri_low_r <= eoi_k;
      else if (aeoi_clr) pri_low_r <= frz_id;
    end
  end

  assign pri_low_w = pri_low_r;
`else
  logic unused_rot;

  assign unused_rot = rot_eoi;
  assign pri_low_w  = ID_W'(NUM_IRQ - 1);
`endif

  assign pri_low          = pri_low_w;
  assign irr_out          = irr;
  assign isr_out          = isr;
  assign bus.int_out      = int_out_r;
  assign bus.vector       = vector_r;
  assign bus.vector_valid = (state == ACK2) && !bus.inta_n;

endmodule

// File: doc/pic_priority_core.md
PIC_PRIORITY_CORE -- requirements
Module: pic_priority_core

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, the number of request lines; legal values are 2..32, powers of two.
REQ-002 SHALL have derived localparam ID_W = $clog2(NUM_IRQ), the width of a channel index.
REQ-003 SHALL have ports: clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have irq_in  input  NUM_IRQ  raw interrupt requests.
REQ-006 SHALL have ltim  input  1  1 = level-triggered, 0 = edge-triggered.
REQ-007 SHALL have aeoi  input  1  automatic EOI enable.
REQ-008 SHALL have imr  input  NUM_IRQ  mask; 1 = channel masked.
REQ-009 SHALL have vec_base  input  8  vector base, low ID_W bits ignored.
REQ-010 SHALL have inta_n  input  1  active-low acknowledge strobe.
REQ-011 SHALL have eoi_ns  input  1  single-cycle non-specific EOI.
REQ-012 SHALL have eoi_sp  input  1  single-cycle specific EOI.
REQ-013 SHALL have eoi_id  input  ID_W  target channel for eoi_sp.
REQ-014 SHALL have rot_eoi  input  1  rotate priority on EOI.
REQ-015 SHALL have int_out  output  1  interrupt request to CPU.
REQ-016 SHALL have vector  output  8  {vec_base[7:ID_W], selected id}.
REQ-017 SHALL have vector_valid  output  1  vector is driven on the data bus.
REQ-018 SHALL have irr_out / isr_out  output  NUM_IRQ  request / in-service registers.
REQ-019 SHALL have pri_low  output  ID_W  lowest-priority channel index.

Function
REQ-020 SHALL set IRR[i] in edge mode on a registered 0->1 transition of irq_in[i], and clear it on first-INTA selection of channel i; in level mode IRR SHALL equal irq_in registered.
REQ-021 SHALL rank priority circularly: highest = pri_low+1 mod NUM_IRQ, lowest = pri_low.
REQ-022 SHALL treat a request as eligible only if it is unmasked and outranks every set ISR bit (fully nested).
REQ-023 SHALL use FSM states IDLE, ACK1, ACK2.
REQ-024 SHALL assert int_out one cycle after an eligible request exists in IDLE, and hold it until the first inta_n falling edge (1->0 sampled).
REQ-025 SHALL, in IDLE on an inta_n fall, freeze the highest eligible id, set its ISR bit, clear int_out, and go to ACK1.
REQ-026 SHALL, if no request is eligible at the first fall, freeze id NUM_IRQ-1 (spurious) and not set ISR.
REQ-027 SHALL, in ACK1 on the next inta_n fall, go to ACK2 with vector_valid=1 while inta_n=0.
REQ-028 SHALL, on the inta_n rise in ACK2, drop vector_valid, clear the frozen ISR bit if aeoi=1 (rotating when rot_eoi=1), and return to IDLE.
REQ-029 SHALL, on eoi_ns, clear the highest-ranked set ISR bit; with no bit set it SHALL do nothing.
REQ-030 SHALL, on eoi_sp, clear ISR[eoi_id].
REQ-031 SHALL, when rot_eoi=1 and an EOI clears bit k, set pri_low=k.
REQ-032 SHALL apply an EOI clear and an INTA set in the same cycle together; if both target the same bit, the set wins.
REQ-033 SHALL, if eoi_ns and eoi_sp coincide, perform eoi_sp only.

Reset
REQ-034 SHALL on rst: FSM=IDLE; IRR, ISR, edge history = 0; int_out=0; vector_valid=0; vector=0; pri_low=NUM_IRQ-1.
REQ-035 SHALL, on rst asserted mid-INTA sequence, abort to IDLE with no ISR update.

Configuration
REQ-036 SHALL, with PIC_PRIORITY_ROTATE_EN defined, implement rot_eoi and pri_low as above.
REQ-037 SHALL, with PIC_PRIORITY_ROTATE_EN undefined, ignore rot_eoi and tie pri_low to NUM_IRQ-1, giving fixed priority with channel 0 highest.

Structure
REQ-038 SHALL place the FSM state enum and the spurious-id constant in a shared package, pic_pkg.
REQ-039 SHALL implement priority resolution as sub-module pic_prio_resolver (combinational: request vector, ISR, pri_low in; valid and id out).

Verification
REQ-040 SHALL cover: NUM_IRQ=8, vec_base=0x20, edge mode, irq_in=0x60, two INTA pulses -> int_out, then ISR=0x20, vector=0x25, IRR=0x40.
REQ-041 SHALL cover: ISR=0x04, irq_in[5] rises -> int_out stays 0; eoi_ns -> ISR=0x00, then int_out=1.
REQ-042 SHALL cover: aeoi=1, rot_eoi=1, acknowledge IR3 -> after the second inta_n rise, ISR=0x00 and pri_low=3; IR4 is now highest.
REQ-043 SHALL cover: INTA with no request -> vector=0x27, ISR unchanged.
REQ-044 SHALL cover: rst asserted during ACK1 -> next cycle FSM IDLE, ISR=0, vector_valid=0.
REQ-045 SHALL cover: NUM_IRQ=16, imr=0xFFFE, irq_in=0x8001 -> vector=vec_base|0x00, IRR bit 15 stays set.
